pwm_multi_controller: RTL and testbench
=======================================

# pwm_multi_controller

Parametrised multi-channel successor to the single-channel fan PWM generator. It drives `CH` PWM outputs from one shared period counter. Per-channel duty targets are double-buffered through a load handshake and applied only at period boundaries, then approached with a programmable per-period slew limit for soft fan start/stop. It sits between the fan-control logic (duty/period producers) and the output pins, behind the same clock-enable prescaler.

## Interface

Parameters:
- `CH`, 4: number of PWM channels (≥1).
- `W`, 8: duty bit width. The period counter is `W+1` bits.
- `STEP`, 4: maximum change of a channel's active duty per period, in counts. 0 means no limit: the duty jumps to its target.

Ports:
- `clk_i`  in  1: system clock.
- `rstn_i`  in  1: reset, asynchronous, active-low.
- `clk_en_i`  in  1: counting enable (prescaler tick). It gates counting and boundary events only.
- `period_i`  in  W+1: period value. The period is `period_i+1` enabled cycles.
- `minDuty_i`  in  W: offset added to every channel duty.
- `duty_i`  in  CH*W: packed duties. Channel k is `duty_i[k*W +: W]`.
- `load_i`  in  1: capture pulse for `period_i`, `minDuty_i` and `duty_i`.
- `pending_o`  out  1: the shadow holds values not yet applied.
- `loadAck_o`  out  1: one-cycle pulse when the shadow is applied.
- `periodStart_o`  out  1: one-cycle pulse on the cycle after each boundary (counter = 0).
- `pwm_o`  out  CH: PWM outputs.

## Operation

- **Registers:**
  - `cnt` (W+1)
  - `period_r` (W+1)
  - shadow `sh_period`, `sh_min`, `sh_duty[CH]`, `pending`
  - per channel `target[k]` and `active[k]`, both W+1 bits, range 0..`period_r`+1

- **Boundary:** a boundary is any clock with `clk_en_i`=1 and `cnt`==`period_r`. At a boundary `cnt`←0. Otherwise `cnt`←`cnt`+1 when `clk_en_i`=1, and holds when `clk_en_i`=0.

- **Load:** `load_i` is sampled on every clock, independent of `clk_en_i`. It copies all inputs into the shadow and sets `pending`. A repeated `load_i` while pending overwrites the shadow, so the latest load wins.

- **Apply (at a boundary with `pending`=1):**
  - `period_r`←`sh_period`.
  - `target[k]`←min(`sh_duty[k]`+`sh_min`, `sh_period`+1). The sum is computed in W+1 bits and cannot overflow.
  - `pending` clears.
  - `loadAck_o` pulses on the next cycle.

- **Load coinciding with a boundary:**
  - If `load_i` and a pending apply occur on the same clock, the old shadow is applied. The new values are captured and `pending` stays 1 for the next boundary.
  - If `load_i` coincides with a boundary with `pending`=0, nothing is applied at that boundary.

- **Slew (every boundary, after apply, using the new target):**
  - If `target[k]` > `active[k]`: `active[k]` += min(`STEP`, difference).
  - If `target[k]` < `active[k]`: `active[k]` -= min(`STEP`, difference).
  - If `STEP`=0: `active[k]`←`target[k]`.
  - `active[k]` is always clamped to `period_r`+1 using the new `period_r`. This covers a period that shrinks below the current active duty.

- **Output:** `pwm_o[k]` = (`cnt` < `active[k]`). This is combinational from registers only, with no input-to-output path.
  - `active`=0 gives constant low.
  - `active`=`period_r`+1 gives constant high (100%).

- **Period 0:** `period_r`=0 makes every enabled cycle a boundary.

## Timing

- **Reset values:** every register is 0 asynchronously. All outputs (`pwm_o`, `pending_o`, `loadAck_o`, `periodStart_o`) are 0 during and after reset. Release is synchronous to the next edge.
- **`pending_o`:** rises the cycle after `load_i`.
- **First visible effect of a load:** duty steps on `pwm_o` begin in the period that starts after the first boundary following capture.
- **`loadAck_o` and `periodStart_o`:** both assert for exactly one `clk_i` cycle, regardless of `clk_en_i`.
- **Reaching a new target:** with `STEP`>0, a target change of D takes ceil(D/`STEP`) periods to reach.
- **Reset mid-operation:** aborts any pending load. Shadow contents are lost.

## Test plan

- **Reset and first load:** reset, then `load_i` with period=9, min=0, duty0=5, `STEP`=0. Required: `pending_o`=1 until the first boundary, then a `loadAck_o` pulse. From then on, ch0 is high 5 of every 10 enabled cycles.
- **Clamp:** period=9, duty=8, min=4. Required: target 10, `pwm_o` constantly high. With duty=0 and min=0, `pwm_o` is constantly low.
- **Slew:** `STEP`=4, active 0, new target 10. Required: active is 4, 8, 10 over three successive periods. A later target of 2 gives 6, then 2.
- **Double load:** load A (duty 3), then load B (duty 7) before the boundary. Required: B applied, one `loadAck_o` only. A load on the boundary clock is deferred to the following period.
- **Enable gating and period shrink:** `clk_en_i` every 3rd clock, so the period is stretched 3× and the pulses stay 1 clk wide. Shrink the period from 20 to 5 with active 15. Required: active clamps to 6 at the apply boundary.

Source files
------------

// File: rtl/pwm_multi_controller.sv
// ---------------------------------------------------------------------------
// pwm_multi_controller
//
// Multi-channel PWM generator built around one shared period counter.
// Duty targets are double-buffered: a load pulse captures period, minimum
// duty and per-channel duties into a shadow. The shadow is applied only at a
// period boundary. Each channel's active duty then moves toward its target
// by at most STEP counts per period, which gives fans a soft start and stop.
//
// Parameters
//   CH    number of PWM channels (>= 1)
//   W     duty width; the period counter is W+1 bits
//   STEP  maximum change of an active duty per period (0 = jump to target)
//
// Ports
//   clk_i          system clock
//   rstn_i         asynchronous active-low reset
//   clk_en_i       prescaler tick; gates counting and boundary events only
//   period_i       period value; the period lasts period_i+1 enabled cycles
//   minDuty_i      offset added to every channel duty
//   duty_i         packed duties, channel k at duty_i[k*W +: W]
//   load_i         capture pulse for period_i, minDuty_i and duty_i
//   pending_o      shadow holds values not yet applied
//   loadAck_o      one-cycle pulse on the cycle after the shadow is applied
//   periodStart_o  one-cycle pulse on the cycle after each boundary
//   pwm_o          PWM outputs, one per channel
// ---------------------------------------------------------------------------
module pwm_multi_controller #(
  parameter int CH   = 4,
  parameter int W    = 8,
  parameter int STEP = 4
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            clk_en_i,
  input  logic [W:0]      period_i,
  input  logic [W-1:0]    minDuty_i,
  input  logic [CH*W-1:0] duty_i,
  input  logic            load_i,
  output logic            pending_o,
  output logic            loadAck_o,
  output logic            periodStart_o,
  output logic [CH-1:0]   pwm_o
);

  // A STEP wider than the duty range can never limit a change, so it
  // saturates to the all-ones value instead of being truncated.
  localparam logic [W:0] STEP_C = (STEP >= (2 ** (W + 1))) ? {(W + 1){1'b1}}
                                                            : (W + 1)'(STEP);

  // min(val, per + 1). The limit needs one extra bit because per + 1 can
  // exceed the W+1 bit range; val never does, so the result always fits.
  function automatic logic [W:0] clamp_duty(input logic [W:0] val,
                                            input logic [W:0] per);
    logic [W+1:0] lim;
    lim = {1'b0, per} + (W + 2)'(1);
    if ({1'b0, val} > lim) begin
      return lim[W:0];
    end
    return val;
  endfunction

  // Requested duty: channel duty plus the common offset, limited to 100%.
  function automatic logic [W:0] target_of(input logic [W-1:0] duty,
                                           input logic [W-1:0] min_duty,
                                           input logic [W:0]   per);
    logic [W:0] sum;
    sum = {1'b0, duty} + {1'b0, min_duty};
    return clamp_duty(sum, per);
  endfunction

  // One period's move of the active duty toward the target.
  function automatic logic [W:0] slew_duty(input logic [W:0] act,
                                           input logic [W:0] tgt);
    logic [W:0] diff;
    if (STEP == 0) begin
      return tgt;
    end
    if (tgt > act) begin
      diff = tgt - act;
      return (diff > STEP_C) ? act + STEP_C : tgt;
    end
    if (tgt < act) begin
      diff = act - tgt;
      return (diff > STEP_C) ? act - STEP_C : tgt;
    end
    return act;
  endfunction

  logic [W:0]   cnt;
  logic [W:0]   period_r;
  logic [W:0]   sh_period;
  logic [W-1:0] sh_min;
  logic [W-1:0] sh_duty [CH];
  logic         pending;
  logic         load_ack_r;
  logic         period_start_r;
  logic [W:0]   target [CH];
  logic [W:0]   active [CH];

  logic         boundary;
  logic         apply;
  logic [W:0]   period_nxt;
  logic [W:0]   target_nxt [CH];

  assign boundary   = clk_en_i && (cnt == period_r);
  assign apply      = boundary && pending;
  assign period_nxt = apply ? sh_period : period_r;

  // Targets as they will be after this clock; the slew at a boundary must
  // already see a freshly applied target and period.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      target_nxt[k] = apply ? target_of(sh_duty[k], sh_min, sh_period)
                            : target[k];
    end
  end

  // Period counter, pending flag and the registered event pulses.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt            <= '0;
      period_r       <= '0;
      pending        <= 1'b0;
      load_ack_r     <= 1'b0;
      period_start_r <= 1'b0;
    end else begin
      load_ack_r     <= apply;
      period_start_r <= boundary;
      period_r       <= period_nxt;
      if (boundary) begin
        cnt <= '0;
      end else if (clk_en_i) begin
        cnt <= cnt + 1'b1;
      end
      // A load on the apply clock re-arms pending for the next boundary.
      if (load_i) begin
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

  // Shadow registers; the latest load always wins.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sh_period <= '0;
      sh_min    <= '0;
      for (int k = 0; k < CH; k++) begin
        sh_duty[k] <= '0;
      end
    end else if (load_i) begin
      sh_period <= period_i;
      sh_min    <= minDuty_i;
      for (int k = 0; k < CH; k++) begin
        sh_duty[k] <= duty_i[k*W +: W];
      end
    end
  end

  // Per-channel target and slewed active duty, updated once per period.
  // The final clamp uses the new period so a shrinking period never leaves
  // an active duty beyond 100%.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < CH; k++) begin
        target[k] <= '0;
        active[k] <= '0;
      end
    end else if (boundary) begin
      for (int k = 0; k < CH; k++) begin
        target[k] <= target_nxt[k];
        active[k] <= clamp_duty(slew_duty(active[k], target_nxt[k]), period_nxt);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      pwm_o[k] = (cnt < active[k]);
    end
  end

  assign pending_o     = pending;
  assign loadAck_o     = load_ack_r;
  assign periodStart_o = period_start_r;

endmodule

// File: tb/tb_pwm_multi_controller.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_controller
//
// Two controller instances (STEP=0 and STEP=4) share the same stimulus. A
// behavioural model tracks counter, shadow, targets and active duties with
// plain integer arithmetic and is compared against both instances on every
// falling clock edge. Directed scenarios additionally measure the high time
// of whole periods and compare it with hand-derived constants.
// ---------------------------------------------------------------------------
module tb_pwm_multi_controller;

  localparam int CH     = 4;
  localparam int W      = 8;
  localparam int STEP_A = 0;
  localparam int STEP_B = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic            en = 1'b0;
  logic            load = 1'b0;
  logic [W:0]      period = '0;
  logic [W-1:0]    mind = '0;
  logic [CH*W-1:0] duty = '0;

  logic            pend_a, ack_a, ps_a;
  logic            pend_b, ack_b, ps_b;
  logic [CH-1:0]   pwm_a, pwm_b;

  int n_tests = 0;
  int n_fail  = 0;
  int en_mode = 3;   // 0 always, 1 every 3rd clock, 2 random, 3 off
  bit checking = 1'b0;
  int hi_a[CH];
  int hi_b[CH];

  // model state
  int m_cnt, m_per, m_shp, m_shm, m_pend, m_ack, m_ps;
  int m_shd[CH];
  int m_tgt[CH];
  int m_act[2][CH];

  pwm_multi_controller #(.CH(CH), .W(W), .STEP(STEP_A)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(en), .period_i(period),
    .minDuty_i(mind), .duty_i(duty), .load_i(load),
    .pending_o(pend_a), .loadAck_o(ack_a), .periodStart_o(ps_a), .pwm_o(pwm_a)
  );

  pwm_multi_controller #(.CH(CH), .W(W), .STEP(STEP_B)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(en), .period_i(period),
    .minDuty_i(mind), .duty_i(duty), .load_i(load),
    .pending_o(pend_b), .loadAck_o(ack_b), .periodStart_o(ps_b), .pwm_o(pwm_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_step();
    bit bnd;
    int a, g, s;
    if (!rstn) begin
      m_cnt = 0; m_per = 0; m_shp = 0; m_shm = 0; m_pend = 0; m_ack = 0; m_ps = 0;
      for (int k = 0; k < CH; k++) begin
        m_shd[k] = 0; m_tgt[k] = 0; m_act[0][k] = 0; m_act[1][k] = 0;
      end
      return;
    end
    bnd   = en && (m_cnt == m_per);
    m_ack = (bnd && m_pend != 0) ? 1 : 0;
    m_ps  = bnd ? 1 : 0;
    if (bnd) begin
      if (m_pend != 0) begin
        m_per = m_shp;
        for (int k = 0; k < CH; k++) begin
          m_tgt[k] = (m_shd[k] + m_shm < m_shp + 1) ? m_shd[k] + m_shm : m_shp + 1;
        end
        m_pend = 0;
      end
      for (int i = 0; i < 2; i++) begin
        s = (i == 0) ? STEP_A : STEP_B;
        for (int k = 0; k < CH; k++) begin
          a = m_act[i][k];
          g = m_tgt[k];
          if (s == 0 || (g - a <= s && a - g <= s)) a = g;
          else if (g > a) a = a + s;
          else a = a - s;
          if (a > m_per + 1) a = m_per + 1;
          m_act[i][k] = a;
        end
      end
      m_cnt = 0;
    end else if (en) begin
      m_cnt = m_cnt + 1;
    end
    if (load) begin
      m_shp = int'(period);
      m_shm = int'(mind);
      for (int k = 0; k < CH; k++) m_shd[k] = int'(duty[k*W +: W]);
      m_pend = 1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    model_step();
  end

  // Continuous comparison of both instances against the model.
  initial forever begin
    logic [CH-1:0] ea, eb;
    @(negedge clk);
    if (checking) begin
      for (int k = 0; k < CH; k++) begin
        ea[k] = (m_cnt < m_act[0][k]);
        eb[k] = (m_cnt < m_act[1][k]);
      end
      chk("cyc_pwm_a", pwm_a, ea);
      chk("cyc_pwm_b", pwm_b, eb);
      chk("cyc_pend_a", pend_a, m_pend);
      chk("cyc_pend_b", pend_b, m_pend);
      chk("cyc_ack_a", ack_a, m_ack);
      chk("cyc_ack_b", ack_b, m_ack);
      chk("cyc_ps_a", ps_a, m_ps);
      chk("cyc_ps_b", ps_b, m_ps);
    end
  end

  // Clock-enable generator, updated just after each rising edge.
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      case (en_mode)
        0: en = 1'b1;
        1: begin div = (div + 1) % 3; en = (div == 0); end
        2: en = 1'($urandom_range(0, 1));
        default: en = 1'b0;
      endcase
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [CH*W-1:0] pack4(input int d0, input int d1, input int d2, input int d3);
    return {W'(d3), W'(d2), W'(d1), W'(d0)};
  endfunction

  task automatic do_load(input int p, input int m, input int d0, input int d1);
    @(negedge clk);
    period = (W + 1)'(p);
    mind   = W'(m);
    duty   = pack4(d0, d1, 0, 0);
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Raise load so that it is sampled on a boundary clock.
  task automatic load_at_bnd(input int p, input int m, input int d0);
    int t;
    t = 0;
    @(negedge clk);
    while (!(m_cnt == m_per && en) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("bnd_found", (t < 500), 1);
    period = (W + 1)'(p);
    mind   = W'(m);
    duty   = pack4(d0, 0, 0, 0);
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int t;
    t = 0;
    while (ack_a !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk(tag, ack_a, 1);
  endtask

  task automatic wait_ps(input string tag);
    int t;
    t = 0;
    while (ps_a !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk(tag, ps_a, 1);
  endtask

  // Starting on a period-start cycle, sum high samples over one period of
  // enabled cycles; returns on the next period-start cycle.
  task automatic meas(input int per);
    int n, t;
    n = 0;
    t = 0;
    for (int k = 0; k < CH; k++) begin hi_a[k] = 0; hi_b[k] = 0; end
    while (n < per + 1 && t < 2000) begin
      if (en) begin
        n++;
        for (int k = 0; k < CH; k++) begin
          hi_a[k] += int'(pwm_a[k]);
          hi_b[k] += int'(pwm_b[k]);
        end
      end
      @(negedge clk);
      t++;
    end
    chk("meas_len", n, per + 1);
  endtask

  initial begin
    int nack;
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int nack;
    #2 rstn = 1'b0;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pwm_a", pwm_a, 0);
    chk("rst_pend_a", pend_a, 0);
    chk("rst_ack_a", ack_a, 0);
    chk("rst_ps_a", ps_a, 0);
    @(posedge clk); #2 rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_pwm_b", pwm_b, 0);
    chk("post_rst_ps_b", ps_b, 0);

    // first load, STEP=0 jumps straight to duty 5
    en_mode = 0;
    do_load(9, 0, 5, 0);
    chk("load_pending", pend_a, 1);
    wait_ack("first_ack");
    chk("first_pend_clr", pend_a, 0);
    meas(9);
    chk("first_duty_a", hi_a[0], 5);
    chk("first_duty_b", hi_b[0], 4);

    // clamp to 100% and zero duty
    do_load(9, 4, 8, 0);
    wait_ack("clamp_ack");
    meas(9);
    chk("clamp_high", hi_a[0], 10);
    chk("clamp_min_only", hi_a[1], 4);
    do_load(9, 0, 0, 0);
    wait_ack("zero_ack");
    meas(9);
    chk("zero_low", hi_a[0], 0);
    repeat (3) meas(9);
    chk("slew_start0", hi_b[0], 0);

    // slew with STEP=4: 4, 8, 10 then 6, 2
    do_load(9, 0, 10, 0);
    wait_ack("slew_ack");
    meas(9); chk("slew_up1", hi_b[0], 4);
    meas(9); chk("slew_up2", hi_b[0], 8);
    meas(9); chk("slew_up3", hi_b[0], 10);
    do_load(9, 0, 2, 0);
    wait_ack("slew_dn_ack");
    meas(9); chk("slew_dn1", hi_b[0], 6);
    meas(9); chk("slew_dn2", hi_b[0], 2);

    // double load: latest wins, single acknowledge
    do_load(9, 0, 3, 0);
    do_load(9, 0, 7, 0);
    wait_ack("dbl_ack");
    nack = 0;
    repeat (25) begin
      @(negedge clk);
      nack += int'(ack_a);
    end
    chk("dbl_single_ack", nack, 0);
    wait_ps("dbl_ps");
    meas(9);
    chk("dbl_latest", hi_a[0], 7);

    // load on a boundary with nothing pending is deferred
    load_at_bnd(9, 0, 4);
    chk("defer_no_ack", ack_a, 0);
    chk("defer_ps", ps_a, 1);
    chk("defer_pend", pend_a, 1);
    wait_ack("defer_ack");
    meas(9);
    chk("defer_duty", hi_a[0], 4);

    // load on the apply boundary: old shadow applied, new stays pending
    do_load(9, 0, 6, 0);
    load_at_bnd(9, 0, 2);
    chk("coll_ack", ack_a, 1);
    chk("coll_pend", pend_a, 1);
    meas(9);
    chk("coll_old", hi_a[0], 6);
    chk("coll_ack2", ack_a, 1);
    chk("coll_pend2", pend_a, 0);
    meas(9);
    chk("coll_new", hi_a[0], 2);

    // enable every 3rd clock, then shrink the period from 20 to 5
    en_mode = 1;
    do_load(20, 0, 15, 0);
    wait_ack("gate_ack");
    chk("gate_ps_on", ps_a, 1);
    @(negedge clk);
    chk("gate_ack_width", ack_a, 0);
    chk("gate_ps_width", ps_a, 0);
    wait_ps("gate_ps");
    meas(20);
    chk("gate_duty", hi_a[0], 15);
    meas(20);
    meas(20);
    chk("gate_b_reached", hi_b[0], 15);
    do_load(5, 0, 15, 0);
    wait_ack("shrink_ack");
    meas(5);
    chk("shrink_a", hi_a[0], 6);
    chk("shrink_b", hi_b[0], 6);

    // randomized traffic against the model, with one mid-run reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) en_mode = int'($urandom_range(0, 2));
      load = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 3) == 0) period = '0;
        else period = (W + 1)'($urandom_range(0, 30));
        mind = W'($urandom_range(0, 255));
        for (int k = 0; k < CH; k++) begin
          if ($urandom_range(0, 1) == 0) duty[k*W +: W] = W'($urandom_range(0, 255));
          else duty[k*W +: W] = W'($urandom_range(0, 12));
        end
        if ($urandom_range(0, 2) != 0) mind = W'($urandom_range(0, 4));
        load = 1'b1;
      end
      if (c == 1500) begin #2 rstn = 1'b0; end
      if (c == 1504) begin #2 rstn = 1'b1; end
    end
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    checking = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
